// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and helpers for the RAM access controller and its data aligner.
package ram_access_ctrl_pkg;

    localparam int unsigned DEFAULT_RAM_ADDR_WIDTH = 10;
    localparam int unsigned DATA_W                 = 32;
    localparam int unsigned STRB_W                 = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_SECOND = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    // Request attributes held from accept until the response retires.
    typedef struct packed {
        logic      we;
        mem_size_t size;
        logic [1:0] off;
        logic      is_unsigned;
        logic      split;
        logic      err;
    } req_ctl_t;

    function automatic logic [STRB_W-1:0] size_mask(input mem_size_t sz);
        case (sz)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_nbytes(input mem_size_t sz);
        case (sz)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl_align.sv
// Combinational lane steering: store rotate/strobe generation and load extract/extend.
module ram_data_align
    import ram_access_ctrl_pkg::*;
(
    input  mem_size_t     i_st_size,
    input  logic [1:0]    i_st_off,
    input  logic [31:0]   i_st_wdata,
    output logic [31:0]   o_st_data,
    output logic [7:0]    o_st_strb8,
    input  mem_size_t     i_ld_size,
    input  logic [1:0]    i_ld_off,
    input  logic          i_ld_unsigned,
    input  logic [63:0]   i_ld_pair,
    output logic [31:0]   o_ld_data
);

    logic [4:0]  w_st_sh;
    logic [4:0]  w_ld_sh;
    logic [31:0] w_ld_word;

    assign w_st_sh = {i_st_off, 3'b000};
    assign w_ld_sh = {i_ld_off, 3'b000};

    // Rotating keeps every byte in the lane it lands in, for both beats of a split.
    assign o_st_data  = 32'(({i_st_wdata, i_st_wdata} << w_st_sh) >> 32);
    assign o_st_strb8 = {4'b0000, size_mask(i_st_size)} << i_st_off;

    assign w_ld_word = 32'(i_ld_pair >> w_ld_sh);

    always_comb begin
        o_ld_data = w_ld_word;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_ld_word[7:0]}
                                               : {{24{w_ld_word[7]}}, w_ld_word[7:0]};
            SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_ld_word[15:0]}
                                               : {{16{w_ld_word[15]}}, w_ld_word[15:0]};
            default: o_ld_data = w_ld_word;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Byte-addressed load/store initiator for a word-addressed RAM; splits misaligned
// accesses into two beats and returns formatted load data.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic [3:0]            ram_wr_strobe,
    input  logic [31:0]           ram_rd_data
);

    localparam logic [1:0] S_IDLE   = LSU_IDLE;
    localparam logic [1:0] S_SECOND = LSU_SECOND;
    localparam logic [1:0] S_RESP   = LSU_RESP;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    req_ctl_t              r_ctl;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [31:0]           r_wdata_rot;
    logic [3:0]            r_strb_hi;
    logic [31:0]           r_lo_q;

    logic [32:0]           w_diff;
    logic                  w_below;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic                  w_last;
    mem_size_t             w_size;
    logic [1:0]            w_off;
    logic [2:0]            w_end;
    logic                  w_split;
    logic                  w_err;
    logic                  w_accept;
    logic [31:0]           w_st_data;
    logic [7:0]            w_st_strb8;
    logic [63:0]           w_pair;
    logic [31:0]           w_ld_data;

    // Range check in 33 bits so addresses below BASE_ADDR cannot wrap into range.
    assign w_diff   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign w_below  = w_diff[32];
    assign w_oor    = (w_diff[31:0] >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_widx   = w_diff[ADDR_WIDTH+1:2];
    assign w_last   = &w_widx;
    assign w_size   = mem_size_t'(req_size);
    assign w_off    = req_addr[1:0];
    assign w_end    = {1'b0, w_off} + size_nbytes(w_size);
    assign w_split  = w_end > 3'd4;
    assign w_err    = w_below | w_oor | (w_split & w_last) | (w_size == SZ_RSVD);
    assign w_accept = req_valid & (r_state == S_IDLE);

    assign w_pair = r_ctl.split ? {ram_rd_data, r_lo_q} : {32'd0, ram_rd_data};

    ram_data_align u_align (
        .i_st_size     (w_size),
        .i_st_off      (w_off),
        .i_st_wdata    (req_wdata),
        .o_st_data     (w_st_data),
        .o_st_strb8    (w_st_strb8),
        .i_ld_size     (r_ctl.size),
        .i_ld_off      (r_ctl.off),
        .i_ld_unsigned (r_ctl.is_unsigned),
        .i_ld_pair     (w_pair),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM port: lo beat straight from the request, hi beat from held state.
    always_comb begin
        w_state_nxt   = r_state;
        ram_rd_en     = 1'b0;
        ram_wr_en     = 1'b0;
        ram_addr      = '0;
        ram_wr_data   = 32'd0;
        ram_wr_strobe = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        ram_rd_en     = ~req_we;
                        ram_wr_en     = req_we;
                        ram_addr      = w_widx;
                        ram_wr_data   = w_st_data;
                        ram_wr_strobe = w_st_strb8[3:0];
                        w_state_nxt   = w_split ? S_SECOND : S_RESP;
                    end
                end
            end
            S_SECOND: begin
                ram_rd_en     = ~r_ctl.we;
                ram_wr_en     = r_ctl.we;
                ram_addr      = r_widx + ADDR_WIDTH'(1);
                ram_wr_data   = r_wdata_rot;
                ram_wr_strobe = r_strb_hi;
                w_state_nxt   = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl       <= '0;
            r_widx      <= '0;
            r_wdata_rot <= 32'd0;
            r_strb_hi   <= 4'd0;
            r_lo_q      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_ctl.we          <= req_we;
                r_ctl.size        <= w_size;
                r_ctl.off         <= w_off;
                r_ctl.is_unsigned <= req_unsigned;
                r_ctl.split       <= w_split;
                r_ctl.err         <= w_err;
                r_widx            <= w_widx;
                r_wdata_rot       <= w_st_data;
                r_strb_hi         <= w_st_strb8[7:4];
            end
            if (r_state == S_SECOND) begin
                r_lo_q <= ram_rd_data;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid & r_ctl.err;
    assign rsp_rdata = (rsp_valid & ~r_ctl.err & ~r_ctl.we) ? w_ld_data : 32'd0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: vector table over a small RAM model plus
// back-to-back and mid-operation reset sequences.
module tb_ram_access_ctrl;

    localparam int unsigned AW = 4;
    localparam logic [31:0] B  = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data, ram_rd_data;
    logic [3:0]    ram_wr_strobe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(B)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .ram_rd_en     (ram_rd_en),
        .ram_wr_en     (ram_wr_en),
        .ram_addr      (ram_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_strobe (ram_wr_strobe),
        .ram_rd_data   (ram_rd_data)
    );

    // RAM model with 1-cycle read latency and a log of every enabled beat.
    logic [31:0] mem [16];
    logic        mem_clr;
    logic [7:0]  nb = 8'd0;
    logic [3:0]  b_addr [256];
    logic [3:0]  b_strb [256];
    logic [31:0] b_data [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_strobe[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];
        if (rst_n && (ram_rd_en || ram_wr_en)) begin
            b_addr[nb] <= ram_addr;
            b_strb[nb] <= ram_wr_strobe;
            b_data[nb] <= ram_wr_data;
            nb         <= nb + 8'd1;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic        chk;
        logic [3:0]  a0, s0, a1, s1;
        logic [31:0] d0;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat;
        v.chk = 1'b0; v.a0 = 4'd0; v.s0 = 4'd0; v.a1 = 4'd0; v.s1 = 4'd0; v.d0 = 32'd0;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Issue one request from posedge+1, return at posedge+1 with the DUT idle again.
    task automatic do_req(input vec_t v, input int idx);
        logic [7:0]  nb0;
        int          lat;
        logic        got_err;
        logic [31:0] got_d;
        string       tag;
        tag = $sformatf("v%0d", idx);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_unsigned = v.uns; req_wdata = v.wdata;
        @(negedge clk);
        chk1({tag, "_ready"}, req_ready, 1'b1);
        nb0 = nb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 0; got_err = 1'b0; got_d = 32'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (rsp_valid && lat == 0) begin
                lat = c; got_err = rsp_err; got_d = rsp_rdata;
            end
        end
        @(posedge clk);
        #1;
        chk32({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk1({tag, "_err"}, got_err, v.err);
        chk32({tag, "_rdata"}, got_d, v.rdata);
        chk32({tag, "_beats"}, 32'(8'(nb - nb0)), v.err ? 32'd0 : 32'(v.lat));
        if (v.chk) begin
            chk32({tag, "_lo_addr"}, 32'(b_addr[nb0]), 32'(v.a0));
            chk32({tag, "_lo_strb"}, 32'(b_strb[nb0]), 32'(v.s0));
            chk32({tag, "_lo_data"}, b_data[nb0], v.d0);
            if (v.lat == 2) begin
                chk32({tag, "_hi_addr"}, 32'(b_addr[8'(nb0 + 8'd1)]), 32'(v.a1));
                chk32({tag, "_hi_strb"}, 32'(b_strb[8'(nb0 + 8'd1)]), 32'(v.s1));
                chk32({tag, "_hi_data"}, b_data[8'(nb0 + 8'd1)], v.d0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    vec_t        vecs [24];
    logic [31:0] bb_exp [3];
    vec_t        bb_req [3];
    logic        rsp_seen;

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'd0;

        // we, addr, size, uns, wdata, err, rdata, latency
        vecs[0]  = mk(1, B + 32'h10, 2, 0, 32'hDEADBEEF, 0, 32'h0,        1);
        vecs[1]  = mk(0, B + 32'h10, 2, 0, 32'h0,        0, 32'hDEADBEEF, 1);
        vecs[2]  = mk(1, B + 32'h13, 0, 0, 32'h12345680, 0, 32'h0,        1);
        vecs[3]  = mk(0, B + 32'h13, 0, 0, 32'h0,        0, 32'hFFFFFF80, 1);
        vecs[4]  = mk(0, B + 32'h13, 0, 1, 32'h0,        0, 32'h00000080, 1);
        vecs[5]  = mk(0, B + 32'h10, 2, 0, 32'h0,        0, 32'h80ADBEEF, 1);
        vecs[6]  = mk(1, B + 32'h06, 2, 0, 32'h11223344, 0, 32'h0,        2);
        vecs[7]  = mk(0, B + 32'h07, 1, 0, 32'h0,        0, 32'h00002233, 2);
        vecs[8]  = mk(0, B + 32'h06, 2, 0, 32'h0,        0, 32'h11223344, 2);
        vecs[9]  = mk(0, B + 32'h06, 1, 1, 32'h0,        0, 32'h00003344, 1);
        vecs[10] = mk(0, B + 32'h09, 0, 0, 32'h0,        0, 32'h00000011, 1);
        vecs[11] = mk(1, B + 32'h0B, 1, 0, 32'h0000A5C3, 0, 32'h0,        2);
        vecs[12] = mk(0, B + 32'h0B, 1, 0, 32'h0,        0, 32'hFFFFA5C3, 2);
        vecs[13] = mk(0, B + 32'h08, 2, 0, 32'h0,        0, 32'hC3001122, 1);
        vecs[14] = mk(0, B + 32'h3E, 2, 0, 32'h0,        1, 32'h0,        1);
        vecs[15] = mk(0, B - 32'h04, 2, 0, 32'h0,        1, 32'h0,        1);
        vecs[16] = mk(0, B + 32'h10, 3, 0, 32'h0,        1, 32'h0,        1);
        vecs[17] = mk(1, B + 32'h40, 2, 0, 32'h55555555, 1, 32'h0,        1);
        vecs[18] = mk(1, B + 32'h3C, 2, 0, 32'hCAFEF00D, 0, 32'h0,        1);
        vecs[19] = mk(0, B + 32'h3F, 0, 0, 32'h0,        0, 32'hFFFFFFCA, 1);
        vecs[20] = mk(0, B + 32'h3D, 0, 1, 32'h0,        0, 32'h000000F0, 1);
        vecs[21] = mk(0, B + 32'h3E, 1, 0, 32'h0,        0, 32'hFFFFCAFE, 1);
        vecs[22] = mk(1, B + 32'h3F, 1, 0, 32'h00001234, 1, 32'h0,        1);
        vecs[23] = mk(0, B + 32'h3C, 2, 0, 32'h0,        0, 32'hCAFEF00D, 1);
        vecs[0].chk = 1;  vecs[0].a0 = 4'd4;  vecs[0].s0 = 4'b1111;  vecs[0].d0 = 32'hDEADBEEF;
        vecs[2].chk = 1;  vecs[2].a0 = 4'd4;  vecs[2].s0 = 4'b1000;  vecs[2].d0 = 32'h80123456;
        vecs[6].chk = 1;  vecs[6].a0 = 4'd1;  vecs[6].s0 = 4'b1100;  vecs[6].d0 = 32'h33441122;
        vecs[6].a1 = 4'd2; vecs[6].s1 = 4'b0011;
        vecs[11].chk = 1; vecs[11].a0 = 4'd2; vecs[11].s0 = 4'b1000; vecs[11].d0 = 32'hC30000A5;
        vecs[11].a1 = 4'd3; vecs[11].s1 = 4'b0001;
        vecs[18].chk = 1; vecs[18].a0 = 4'd15; vecs[18].s0 = 4'b1111; vecs[18].d0 = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk1("rst_rd_en", ram_rd_en, 1'b0);
        chk1("rst_wr_en", ram_wr_en, 1'b0);
        chk32("rst_strobe", 32'(ram_wr_strobe), 32'd0);
        rst_n = 1'b1; mem_clr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) do_req(vecs[i], i);

        // Back-to-back aligned loads with req_valid held high.
        bb_req[0] = mk(0, B + 32'h10, 2, 0, 32'h0, 0, 32'h0, 1); bb_exp[0] = 32'h80ADBEEF;
        bb_req[1] = mk(0, B + 32'h3C, 2, 0, 32'h0, 0, 32'h0, 1); bb_exp[1] = 32'hCAFEF00D;
        bb_req[2] = mk(0, B + 32'h13, 0, 0, 32'h0, 0, 32'h0, 1); bb_exp[2] = 32'hFFFFFF80;
        req_valid = 1'b1; req_we = 1'b0; req_addr = bb_req[0].addr; req_size = bb_req[0].size;
        req_unsigned = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1($sformatf("b2b_ready_c%0d", k), req_ready, (k % 2) == 0);
            if (k % 2 == 1) begin
                chk1($sformatf("b2b_rsp_valid_c%0d", k), rsp_valid, 1'b1);
                chk32($sformatf("b2b_rdata_c%0d", k), rsp_rdata, bb_exp[k / 2]);
            end
            @(posedge clk);
            #1;
            if (k % 2 == 0) begin
                if (k / 2 < 2) begin
                    req_addr = bb_req[k / 2 + 1].addr;
                    req_size = bb_req[k / 2 + 1].size;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end

        // Reset during the hi beat of a split store: lo lanes only, no response.
        req_valid = 1'b1; req_we = 1'b1; req_addr = B + 32'h21; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk1("split_second_ready", req_ready, 1'b0);
        chk1("split_second_wr_en", ram_wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("midrst_wr_en", ram_wr_en, 1'b0);
        chk1("midrst_rd_en", ram_rd_en, 1'b0);
        chk32("midrst_strobe", 32'(ram_wr_strobe), 32'd0);
        chk1("midrst_ready", req_ready, 1'b1);
        rsp_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen = 1'b1;
            if (c == 2) rst_n = 1'b1;
        end
        chk1("midrst_no_rsp", rsp_seen, 1'b0);
        chk32("midrst_mem_lo", mem[8], 32'hB2C3D400);
        chk32("midrst_mem_hi", mem[9], 32'h00000000);
        @(posedge clk);
        #1;
        do_req(mk(0, B + 32'h20, 2, 0, 32'h0, 0, 32'hB2C3D400, 1), 100);
        do_req(mk(0, B + 32'h24, 2, 0, 32'h0, 0, 32'h00000000, 1), 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
